ym_bus_responder: RTL and testbench

YM_BUS_RESPONDER -- requirements
Module: ym_bus_responder

---
 rtl/ym_bus_responder.sv | 163 ++++++++++++++++
 tb/tb_ym_bus_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ym_bus_responder.sv
// PSG-style bus responder: synchronizes the BDIR/BC1/DA bus, decodes latch/write/read
// cycles into a 16-entry register file, and exposes write events and I/O ports to the sound core.
module ym_bus_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [3:0]  CHIP_ADDR   = 4'h0
) (
    input  logic       cpu_clock,
    input  logic       reset,
    input  logic       bdir,
    input  logic       bc1,
    input  logic [7:0] da_in,
    output logic [7:0] da_out,
    output logic       da_oe,
    input  logic [7:0] port_a_in,
    input  logic [7:0] port_b_in,
    output logic [7:0] port_a_out,
    output logic [7:0] port_b_out,
    output logic       port_a_oe,
    output logic       port_b_oe,
    output logic       wr_strobe,
    output logic [3:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic [3:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       env_restart
);

    typedef enum logic [1:0] {ST_IDLE, ST_LATCH, ST_WRITE, ST_READ} state_e;

    state_e     state_q, state_d;
    logic [9:0] sync_q [SYNC_STAGES];
    logic [9:0] sync_d [SYNC_STAGES];
    logic [9:0] hist_q, hist_d;
    logic [7:0] regs_q [16];
    logic [7:0] regs_d [16];
    logic [3:0] addr_q, addr_d;
    logic       sel_q, sel_d;
    logic       wr_strobe_q, wr_strobe_d;
    logic [3:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       env_restart_q, env_restart_d;
    logic [7:0] rd_data_q, rd_data_d;

    logic [9:0] bus_now;
    logic       stable;
    logic [1:0] mode;
    logic [7:0] bus_data;
    logic [7:0] wr_value;

    function automatic logic [7:0] reg_mask(input logic [3:0] a);
        case (a)
            4'd1, 4'd3, 4'd5, 4'd13: reg_mask = 8'h0F;
            4'd6, 4'd8, 4'd9, 4'd10: reg_mask = 8'h1F;
            default:                 reg_mask = 8'hFF;
        endcase
    endfunction

    assign bus_now  = sync_q[SYNC_STAGES-1];
    assign stable   = (bus_now == hist_q);
    assign mode     = bus_now[9:8];
    assign bus_data = bus_now[7:0];
    assign wr_value = bus_data & reg_mask(addr_q);

    always_comb begin
        sync_d[0] = {bdir, bc1, da_in};
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        hist_d = bus_now;
    end

    // State register
    always_ff @(posedge cpu_clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state: only a mode seen on two consecutive synchronized samples counts
    always_comb begin
        state_d = state_q;
        if (stable) begin
            case (mode)
                2'b00: state_d = ST_IDLE;
                2'b01: state_d = ST_READ;
                2'b10: state_d = ST_WRITE;
                2'b11: state_d = ST_LATCH;
            endcase
        end
    end

    // Output decode
    always_comb begin
        da_oe  = (state_q == ST_READ);
        da_out = 8'h00;
        if (state_q == ST_READ) begin
            if (!sel_q)                                 da_out = 8'hFF;
            else if (addr_q == 4'd14 && !regs_q[7][6])  da_out = port_a_in;
            else if (addr_q == 4'd15 && !regs_q[7][7])  da_out = port_b_in;
            else                                        da_out = regs_q[addr_q];
        end
    end

    // Entry actions fire on the same edge the state register takes the new state
    always_comb begin
        regs_d        = regs_q;
        addr_d        = addr_q;
        sel_d         = sel_q;
        wr_strobe_d   = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        env_restart_d = 1'b0;
        rd_data_d     = regs_q[rd_addr];
        if (state_d != state_q) begin
            if (state_d == ST_LATCH) begin
                addr_d = bus_data[3:0];
                sel_d  = (bus_data[7:4] == CHIP_ADDR);
            end else if (state_d == ST_WRITE && sel_q) begin
                regs_d[addr_q] = wr_value;
                wr_strobe_d    = 1'b1;
                wr_addr_d      = addr_q;
                wr_data_d      = wr_value;
                env_restart_d  = (addr_q == 4'd13);
            end
        end
    end

    always_ff @(posedge cpu_clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            for (int unsigned i = 0; i < 16; i++)          regs_q[i] <= '0;
            hist_q        <= '0;
            addr_q        <= '0;
            sel_q         <= 1'b1;
            wr_strobe_q   <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            env_restart_q <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            sync_q        <= sync_d;
            regs_q        <= regs_d;
            hist_q        <= hist_d;
            addr_q        <= addr_d;
            sel_q         <= sel_d;
            wr_strobe_q   <= wr_strobe_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            env_restart_q <= env_restart_d;
            rd_data_q     <= rd_data_d;
        end
    end

    assign wr_strobe   = wr_strobe_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign env_restart = env_restart_q;
    assign rd_data     = rd_data_q;
    assign port_a_out  = regs_q[14];
    assign port_b_out  = regs_q[15];
    assign port_a_oe   = regs_q[7][6];
    assign port_b_oe   = regs_q[7][7];

endmodule

// File: tb/tb_ym_bus_responder.sv
// Bench for ym_bus_responder: directed bus scenarios plus randomized bus traffic
// checked against a transaction-level model of the register file and write events.
module tb_ym_bus_responder;

    localparam logic [3:0] CHIP = 4'h0;
    localparam logic [1:0] M_IDLE = 2'b00, M_READ = 2'b01, M_WRITE = 2'b10, M_LATCH = 2'b11;

    logic       cpu_clock = 1'b0;
    logic       reset;
    logic       bdir, bc1;
    logic [7:0] da_in, da_out;
    logic       da_oe;
    logic [7:0] port_a_in, port_b_in, port_a_out, port_b_out;
    logic       port_a_oe, port_b_oe;
    logic       wr_strobe;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       env_restart;

    ym_bus_responder #(.SYNC_STAGES(2), .CHIP_ADDR(CHIP)) dut (
        .cpu_clock(cpu_clock), .reset(reset), .bdir(bdir), .bc1(bc1), .da_in(da_in),
        .da_out(da_out), .da_oe(da_oe), .port_a_in(port_a_in), .port_b_in(port_b_in),
        .port_a_out(port_a_out), .port_b_out(port_b_out), .port_a_oe(port_a_oe),
        .port_b_oe(port_b_oe), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .env_restart(env_restart)
    );

    always #5 cpu_clock = ~cpu_clock;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Model: bus-visible state is 0 idle, 1 latch, 2 write, 3 read
    int         mstate;
    logic [7:0] mreg [16];
    logic [3:0] maddr;
    logic       msel;
    logic [12:0] exp_q[$];
    logic [12:0] got_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge cpu_clock) begin
        if (wr_strobe === 1'b1 || env_restart === 1'b1)
            got_q.push_back({env_restart, wr_addr, wr_data});
    end

    function automatic logic [7:0] mask_of(input logic [3:0] a);
        if (a == 1 || a == 3 || a == 5 || a == 13) return 8'h0F;
        if (a == 6 || a == 8 || a == 9 || a == 10) return 8'h1F;
        return 8'hFF;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mreg[i] = 8'h00;
        maddr = 4'd0; msel = 1'b1; mstate = 0;
    endtask

    task automatic model_apply(input logic [1:0] mode, input logic [7:0] data);
        int target;
        logic [7:0] v;
        target = (mode == M_READ) ? 3 : (mode == M_WRITE) ? 2 : (mode == M_LATCH) ? 1 : 0;
        if (target == 0) mstate = 0;
        else if (target != mstate) begin
            mstate = target;
            if (target == 1) begin
                maddr = data[3:0];
                msel  = (data[7:4] == CHIP);
            end else if (target == 2 && msel) begin
                v = data & mask_of(maddr);
                mreg[maddr] = v;
                exp_q.push_back({maddr == 4'd13, maddr, v});
            end
        end
    endtask

    function automatic logic [7:0] exp_da_out();
        if (mstate != 3) return 8'h00;
        if (!msel) return 8'hFF;
        if (maddr == 14 && !mreg[7][6]) return port_a_in;
        if (maddr == 15 && !mreg[7][7]) return port_b_in;
        return mreg[maddr];
    endfunction

    // Drive one bus mode for n cycles; a mode held under 2 cycles is never seen
    task automatic op(input logic [1:0] mode, input logic [7:0] data, input int unsigned n);
        {bdir, bc1} = mode;
        da_in = data;
        port_a_in = 8'($urandom);
        port_b_in = 8'($urandom);
        rd_addr = 4'($urandom);
        repeat (n) @(posedge cpu_clock);
        #1;
        if (n >= 2) model_apply(mode, data);
        if (n >= 5) begin
            chk("da_oe", da_oe, mstate == 3);
            chk("da_out", da_out, exp_da_out());
            chk("rd_data", rd_data, mreg[rd_addr]);
        end
    endtask

    task automatic check_strobes(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk({tag, "_event"}, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            @(posedge cpu_clock); #1;
            chk(tag, {a[7:0], rd_data}, {a[7:0], mreg[a]});
        end
        chk("port_a_out", port_a_out, mreg[14]);
        chk("port_b_out", port_b_out, mreg[15]);
        chk("port_a_oe", port_a_oe, mreg[7][6]);
        chk("port_b_oe", port_b_oe, mreg[7][7]);
    endtask

    initial begin
        logic [1:0] prev_mode, m;
        logic [7:0] d;
        int unsigned n;

        reset = 1'b1;
        {bdir, bc1} = M_WRITE; da_in = 8'h5A;
        port_a_in = 8'h00; port_b_in = 8'h00; rd_addr = 4'd0;
        model_reset();
        repeat (3) @(posedge cpu_clock);
        #1;
        chk("rst_da_oe", da_oe, 1'b0);
        chk("rst_da_out", da_out, 8'h00);
        chk("rst_rd_data", rd_data, 8'h00);
        chk("rst_wr_strobe", wr_strobe, 1'b0);
        chk("rst_env_restart", env_restart, 1'b0);
        {bdir, bc1} = M_IDLE;
        reset = 1'b0;
        got_q.delete();
        op(M_IDLE, 8'h00, 6);
        sweep("rst_reg");

        // Port direction setup through R7
        op(M_LATCH, 8'h07, 4); op(M_IDLE, 8'h00, 4);
        op(M_WRITE, 8'hF8, 4); op(M_IDLE, 8'h00, 6);
        chk("r7_port_a_oe", port_a_oe, 1'b1);
        chk("r7_port_b_oe", port_b_oe, 1'b1);
        check_strobes("r7_write");

        // Masked write then read back over the bus
        op(M_LATCH, 8'h01, 4); op(M_WRITE, 8'hFF, 5); op(M_READ, 8'h00, 6);
        chk("r1_da_oe", da_oe, 1'b1);
        chk("r1_da_out", da_out, 8'h0F);
        op(M_IDLE, 8'h00, 6);
        check_strobes("r1_write");

        // Other chip selected: write ignored, reads float high
        op(M_LATCH, 8'h35, 4); op(M_WRITE, 8'hAA, 5); op(M_READ, 8'h00, 6);
        chk("desel_da_out", da_out, 8'hFF);
        op(M_IDLE, 8'h00, 6);
        check_strobes("desel");
        sweep("desel_reg");

        // One-cycle glitch ignored, four-cycle write accepted
        op(M_LATCH, 8'h02, 4); op(M_IDLE, 8'h00, 6);
        op(M_WRITE, 8'h11, 1); op(M_IDLE, 8'h00, 6);
        check_strobes("glitch");
        op(M_WRITE, 8'h11, 4); op(M_IDLE, 8'h00, 6);
        check_strobes("held4");

        // Repeated envelope-shape writes
        op(M_LATCH, 8'h0D, 4);
        op(M_WRITE, 8'h0E, 4); op(M_IDLE, 8'h00, 4);
        op(M_WRITE, 8'h0E, 4); op(M_IDLE, 8'h00, 6);
        chk("env_events", exp_q.size(), 2);
        check_strobes("env");

        // Reset during a held write, then the write is seen again after release
        op(M_LATCH, 8'h03, 4); op(M_IDLE, 8'h00, 6);
        {bdir, bc1} = M_WRITE; da_in = 8'h5A; rd_addr = 4'd3;
        repeat (4) @(posedge cpu_clock);
        #1;
        model_apply(M_WRITE, 8'h5A);
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge cpu_clock);
        #1;
        chk("mid_rst_da_oe", da_oe, 1'b0);
        chk("mid_rst_strobe", wr_strobe, 1'b0);
        reset = 1'b0;
        @(posedge cpu_clock); #1;
        chk("mid_rst_r3_cleared", rd_data, 8'h00);
        repeat (7) @(posedge cpu_clock); #1;
        model_apply(M_WRITE, 8'h5A);
        op(M_IDLE, 8'h00, 6);
        check_strobes("mid_rst");
        sweep("mid_rst_reg");

        // Randomized traffic
        prev_mode = M_IDLE;
        for (int k = 0; k < 300; k++) begin
            do m = 2'($urandom); while (m == prev_mode);
            n = ($urandom_range(0, 4) == 0) ? 1 : $urandom_range(2, 7);
            if (m == M_READ && n != 1) n = $urandom_range(5, 8);
            d = 8'($urandom);
            if (m == M_LATCH && $urandom_range(0, 3) != 0) d[7:4] = CHIP;
            op(m, d, n);
            prev_mode = m;
        end
        op(M_IDLE, 8'h00, 8);
        check_strobes("rand");
        sweep("rand_reg");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
